// File: rtl/onehot_alloc_tracker.sv
// rtl/onehot_alloc_tracker.sv - lowest-free slot allocator with one-hot grant and occupancy tracking
// Busy bits, free count and error flag are the only state; everything else decodes from them.
module onehot_alloc_tracker #(
    parameter int IDX_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               alloc_req,
    output logic               alloc_gnt,
    output logic [IDX_W-1:0]   alloc_idx,
    output logic [(1<<IDX_W)-1:0] alloc_onehot,
    input  logic               free_vld,
    input  logic [IDX_W-1:0]   free_idx,
    output logic               free_err,
    output logic [(1<<IDX_W)-1:0] busy_vec,
    output logic [IDX_W:0]     free_cnt,
    output logic               full,
    output logic               all_free
);
    localparam int N     = 1 << IDX_W;
    localparam int CNT_W = IDX_W + 1;

    logic          free_legal;
    logic [N-1:0]  clr_mask;

    // Scan downward so the last hit is the lowest free slot; idx stays 0 when full.
    always_comb begin
        alloc_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy_vec[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
    end

    assign full         = (free_cnt == '0);
    assign all_free     = (free_cnt == CNT_W'(N));
    assign alloc_gnt    = alloc_req & ~full;
    assign alloc_onehot = alloc_gnt ? (N'(1) << alloc_idx) : '0;

    assign free_legal = free_vld & busy_vec[free_idx];
    assign clr_mask   = free_legal ? (N'(1) << free_idx) : '0;

    // Grant uses pre-update busy bits, so a slot freed this cycle is only grantable next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_vec <= '0;
            free_cnt <= CNT_W'(N);
            free_err <= 1'b0;
        end else if (flush) begin
            busy_vec <= '0;
            free_cnt <= CNT_W'(N);
            free_err <= 1'b0;
        end else begin
            busy_vec <= (busy_vec | alloc_onehot) & ~clr_mask;
            free_cnt <= free_cnt - CNT_W'(alloc_gnt) + CNT_W'(free_legal);
            free_err <= free_vld & ~busy_vec[free_idx];
        end
    end
endmodule
